lock_access_ctrl: RTL and testbench

LOCK_ACCESS_CTRL -- requirements
Module: lock_access_ctrl

---
 rtl/lock_access_ctrl.sv | 120 ++++++++++++
 tb/tb_lock_access_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lock_access_ctrl.sv
// lock_access_ctrl: 4-digit keypad lock with timed unlock, PIN programming and intrusion lockout
module lock_access_ctrl #(
  parameter logic [15:0] DEFAULT_PIN = 16'h1234,
  parameter int MAX_FAIL = 3,
  parameter int UNLOCK_CYC = 8,
  parameter int LOCKOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic       digit_vld,
  input  logic       enter,
  input  logic       clear,
  input  logic       set_req,
  output logic       lock,
  output logic       intrusion_alert,
  output logic [1:0] fail_cnt,
  output logic [2:0] state
);
  typedef enum logic [2:0] {IDLE = 3'd0, ENTRY = 3'd1, CHECK = 3'd2, OPEN = 3'd3, LOCKOUT = 3'd4} state_t;
  localparam int TW = $clog2((UNLOCK_CYC > LOCKOUT_CYC ? UNLOCK_CYC : LOCKOUT_CYC) + 1);
  localparam logic [1:0] MAXF = 2'(MAX_FAIL);
  state_t st;
  logic [15:0] buffer, pin;
  logic [2:0] count;
  logic [TW-1:0] unlock_tmr, lockout_tmr;
  logic [15:0] shifted;
  logic [1:0] fail_nxt;
  logic match, take_digit;
  assign shifted = {buffer[11:0], digit};
  assign match = (count == 3'd4) && (buffer == pin);
  assign fail_nxt = (fail_cnt == MAXF) ? MAXF : fail_cnt + 2'd1;
  assign take_digit = digit_vld && !clear && !enter && !set_req && (count != 3'd4);
  assign state = st;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      lock <= 1'b0;
      intrusion_alert <= 1'b0;
      fail_cnt <= 2'd0;
      buffer <= 16'd0;
      count <= 3'd0;
      unlock_tmr <= '0;
      lockout_tmr <= '0;
      pin <= DEFAULT_PIN;
    end else begin
      case (st)
        IDLE: if (digit_vld) begin
          buffer <= shifted;
          count <= 3'd1;
          st <= ENTRY;
        end
        ENTRY: begin
          if (clear) begin
            buffer <= 16'd0;
            count <= 3'd0;
            st <= IDLE;
          end else if (enter) begin
            st <= CHECK;
          end else if (take_digit) begin
            buffer <= shifted;
            count <= count + 3'd1;
          end
        end
        CHECK: begin
          buffer <= 16'd0;
          count <= 3'd0;
          if (match) begin
            st <= OPEN;
            lock <= 1'b1;
            fail_cnt <= 2'd0;
            unlock_tmr <= TW'(UNLOCK_CYC);
          end else begin
            fail_cnt <= fail_nxt;
            if (fail_nxt == MAXF) begin
              st <= LOCKOUT;
              intrusion_alert <= 1'b1;
              lockout_tmr <= TW'(LOCKOUT_CYC);
            end else begin
              st <= IDLE;
            end
          end
        end
        OPEN: begin
          unlock_tmr <= unlock_tmr - TW'(1);
          if (clear || enter) begin
            buffer <= 16'd0;
            count <= 3'd0;
          end else if (set_req) begin
            if (count == 3'd4) begin
              pin <= buffer;
              buffer <= 16'd0;
              count <= 3'd0;
            end
          end else if (take_digit) begin
            buffer <= shifted;
            count <= count + 3'd1;
          end
          // timeout and manual relock both leave with an empty buffer and a stopped timer
          if ((enter && !clear) || unlock_tmr == TW'(1)) begin
            st <= IDLE;
            lock <= 1'b0;
            buffer <= 16'd0;
            count <= 3'd0;
            unlock_tmr <= '0;
          end
        end
        LOCKOUT: begin
          lockout_tmr <= lockout_tmr - TW'(1);
          if (lockout_tmr == TW'(1)) begin
            st <= IDLE;
            intrusion_alert <= 1'b0;
            fail_cnt <= 2'd0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lock_access_ctrl.sv
// tb_lock_access_ctrl: directed scenarios plus randomized traffic against a queue-based reference model
module tb_lock_access_ctrl;
  localparam int UNLOCK = 8;
  localparam int LOCKOUT = 16;
  localparam int MAXF = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] digit = 4'd0;
  logic digit_vld = 1'b0, enter = 1'b0, clear = 1'b0, set_req = 1'b0;
  logic lock, intrusion_alert;
  logic [1:0] fail_cnt;
  logic [2:0] state;
  int errors = 0;
  int checks = 0;
  int m_mode, m_fail, m_left;
  logic [15:0] m_pin;
  logic [3:0] q[$];

  lock_access_ctrl dut (
    .clk(clk), .rst(rst), .digit(digit), .digit_vld(digit_vld), .enter(enter),
    .clear(clear), .set_req(set_req), .lock(lock), .intrusion_alert(intrusion_alert),
    .fail_cnt(fail_cnt), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] packed_q();
    logic [15:0] v;
    v = '0;
    foreach (q[i]) v = {v[11:0], q[i]};
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_fail = 0;
    m_left = 0;
    m_pin = 16'h1234;
    q.delete();
  endtask

  task automatic model(input logic [3:0] d, input logic v, e, c, s);
    case (m_mode)
      0: if (v) begin q.delete(); q.push_back(d); m_mode = 1; end
      1: begin
        if (c) begin q.delete(); m_mode = 0; end
        else if (e) m_mode = 2;
        else if (!s && v && q.size() < 4) q.push_back(d);
      end
      2: begin
        if (q.size() == 4 && packed_q() == m_pin) begin
          m_mode = 3; m_fail = 0; m_left = UNLOCK;
        end else begin
          m_fail = (m_fail + 1 > MAXF) ? MAXF : m_fail + 1;
          m_mode = (m_fail == MAXF) ? 4 : 0;
          m_left = LOCKOUT;
        end
        q.delete();
      end
      3: begin
        m_left--;
        if (c || e) q.delete();
        else if (s) begin
          if (q.size() == 4) begin m_pin = packed_q(); q.delete(); end
        end else if (v && q.size() < 4) q.push_back(d);
        if ((e && !c) || m_left == 0) begin m_mode = 0; q.delete(); end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin m_mode = 0; m_fail = 0; end
      end
    endcase
  endtask

  task automatic expect_eq(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    expect_eq({tag, ".lock"}, int'(lock), (m_mode == 3) ? 1 : 0);
    expect_eq({tag, ".alert"}, int'(intrusion_alert), (m_mode == 4) ? 1 : 0);
    expect_eq({tag, ".fail_cnt"}, int'(fail_cnt), m_fail);
    expect_eq({tag, ".state"}, int'(state), m_mode);
  endtask

  task automatic step(input logic [3:0] d, input logic v, e, c, s);
    digit = d; digit_vld = v; enter = e; clear = c; set_req = s;
    @(posedge clk);
    model(d, v, e, c, s);
    #1 check_all("model");
    digit_vld = 0; enter = 0; clear = 0; set_req = 0;
  endtask

  task automatic dig(input logic [3:0] d); step(d, 1, 0, 0, 0); endtask
  task automatic ent(); step(4'd0, 0, 1, 0, 0); endtask
  task automatic idle(); step(4'd0, 0, 0, 0, 0); endtask

  task automatic try_code(input logic [15:0] code);
    for (int i = 0; i < 4; i++) dig(4'(code >> (12 - 4 * i)));
    ent();
    idle();
  endtask

  task automatic hard_reset(input string tag);
    #2 rst = 1'b0;
    model_reset();
    #1 check_all(tag);
    @(negedge clk) rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 check_all("por");
    expect_eq("por.state", int'(state), 0);
    expect_eq("por.lock", int'(lock), 0);
    @(negedge clk) rst = 1'b1;

    // basic open and timed relock
    dig(4'h1); dig(4'h2); dig(4'h3); dig(4'h4);
    ent();
    expect_eq("s1.check", int'(state), 2);
    idle();
    expect_eq("s1.open", int'(state), 3);
    expect_eq("s1.lock_rise", int'(lock), 1);
    for (int i = 0; i < UNLOCK - 1; i++) begin
      idle();
      expect_eq("s1.lock_hold", int'(lock), 1);
    end
    idle();
    expect_eq("s1.lock_fall", int'(lock), 0);
    expect_eq("s1.idle", int'(state), 0);

    // program a new PIN while open
    try_code(16'h1234);
    dig(4'hA); dig(4'hB); dig(4'hC); dig(4'hD);
    step(4'd0, 0, 0, 0, 1);
    expect_eq("s2.still_open", int'(lock), 1);
    ent();
    expect_eq("s2.relock", int'(state), 0);
    try_code(16'h1234);
    expect_eq("s2.old_pin_fail", int'(fail_cnt), 1);
    expect_eq("s2.old_pin_lock", int'(lock), 0);
    try_code(16'hABCD);
    expect_eq("s2.new_pin_open", int'(lock), 1);
    expect_eq("s2.fail_clr", int'(fail_cnt), 0);
    ent();

    // three failures into lockout
    try_code(16'h5555);
    expect_eq("s3.fail1", int'(fail_cnt), 1);
    try_code(16'h5555);
    expect_eq("s3.fail2", int'(fail_cnt), 2);
    try_code(16'h5555);
    expect_eq("s3.lockout", int'(state), 4);
    expect_eq("s3.alert", int'(intrusion_alert), 1);
    for (int i = 0; i < LOCKOUT - 1; i++) begin
      dig(4'h7);
      expect_eq("s3.alert_hold", int'(intrusion_alert), 1);
    end
    dig(4'h7);
    expect_eq("s3.alert_off", int'(intrusion_alert), 0);
    expect_eq("s3.fail_zero", int'(fail_cnt), 0);
    expect_eq("s3.idle", int'(state), 0);

    // short entry and a surplus fifth digit
    hard_reset("s4.rst");
    dig(4'h1); dig(4'h2); ent(); idle();
    expect_eq("s4.short_fail", int'(fail_cnt), 1);
    dig(4'h1); dig(4'h2); dig(4'h3); dig(4'h4); dig(4'h9); ent(); idle();
    expect_eq("s4.open", int'(lock), 1);
    expect_eq("s4.fail_clr", int'(fail_cnt), 0);
    ent();

    // clear beats enter; manual relock at cycle 3
    dig(4'h1); dig(4'h2); ent(); idle();
    dig(4'h7);
    step(4'd0, 0, 1, 1, 0);
    expect_eq("s5.clr_idle", int'(state), 0);
    expect_eq("s5.fail_kept", int'(fail_cnt), 1);
    try_code(16'h1234);
    idle(); idle();
    ent();
    expect_eq("s5.relock", int'(lock), 0);

    // async reset during OPEN and LOCKOUT restores the default PIN
    try_code(16'h1234);
    dig(4'hA); dig(4'hB); dig(4'hC); dig(4'hD);
    step(4'd0, 0, 0, 0, 1);
    ent();
    try_code(16'hABCD);
    idle(); idle(); idle();
    hard_reset("s6.rst_open");
    expect_eq("s6.lock_drop", int'(lock), 0);
    try_code(16'h5555); try_code(16'h5555); try_code(16'h5555);
    idle(); idle();
    hard_reset("s6.rst_lockout");
    expect_eq("s6.alert_drop", int'(intrusion_alert), 0);
    try_code(16'h1234);
    expect_eq("s6.default_pin", int'(lock), 1);

    // randomized traffic
    hard_reset("rand.rst");
    repeat (60) begin
      logic [15:0] code;
      int n;
      code = ($urandom_range(0, 1) == 1) ? m_pin : 16'($urandom);
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) step(4'(code >> (12 - 4 * (i % 4))), 1, 0, ($urandom_range(0, 19) == 0), 0);
      ent();
      repeat ($urandom_range(1, 12))
        step(4'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
